// File: rtl/mul_booth_seq.sv
// mul_booth_seq: iterative radix-4 Booth multiplier, signed or unsigned operands.
// One Booth digit retires per clock. The product appears on HI/LO together with a
// one-cycle done pulse.
// Optional feature macro: MUL_EARLY_EXIT_EN. When it is defined, the multiply
// finishes as soon as every remaining multiplier digit is zero. When it is
// undefined, every operation takes the fixed K = WIDTH/2 + 1 iterations.
//
// state | meaning
// IDLE  | waiting for start; HI/LO keep the last result
// RUN   | one Booth digit is accumulated per cycle
// DONE  | done pulse is high; the FSM returns to IDLE on the next edge
module mul_booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int K  = WIDTH / 2 + 1;
    localparam int AW = 2 * WIDTH + 4;
    localparam int BW = WIDTH + 3;
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   acc;
    // The multiplicand is kept pre-shifted, so the digit weight 4^i is built in.
    logic [AW-1:0]   mcand;
    // The multiplier is extended to WIDTH+2 bits, with the overlap bit b(-1) in bit 0.
    logic [BW-1:0]   mplier;
    logic [CW-1:0]   cnt;

    logic [AW-1:0]   digit;
    logic [AW-1:0]   acc_next;
    logic [BW-1:0]   mplier_next;
    logic            last_digit;
    logic            ext_a;
    logic            ext_b;

    // Booth digit decode, accumulator update and the end-of-operation decision
    always_comb begin
        digit = '0;
        unique case (mplier[2:0])
            3'b001, 3'b010: digit = mcand;
            3'b011:         digit = {mcand[AW-2:0], 1'b0};
            3'b100:         digit = -{mcand[AW-2:0], 1'b0};
            3'b101, 3'b110: digit = -mcand;
            default:        digit = '0;
        endcase
        acc_next = acc + digit;
        // The arithmetic shift keeps the fill bits equal to the extension bit.
        // After the shift, "all zeros or all ones" means every remaining digit is zero.
        mplier_next = {{2{mplier[BW-1]}}, mplier[BW-1:2]};
        last_digit  = (cnt == CW'(K - 1));
`ifdef MUL_EARLY_EXIT_EN
        if ((mplier_next == '0) || (mplier_next == '1)) begin
            last_digit = 1'b1;
        end
`endif
        ext_a = signed_mode & A[WIDTH-1];
        ext_b = signed_mode & B[WIDTH-1];
    end

    // Control FSM, with the datapath registers and the registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc    <= '0;
                        cnt    <= '0;
                        mcand  <= {{(WIDTH + 4){ext_a}}, A};
                        mplier <= {{2{ext_b}}, B, 1'b0};
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= {mcand[AW-3:0], 2'b00};
                    mplier <= mplier_next;
                    cnt    <= cnt + CW'(1);
                    if (last_digit) begin
                        HI    <= acc_next[2*WIDTH-1:WIDTH];
                        LO    <= acc_next[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_booth_seq.md
# mul_booth_seq

Parametrised, iterative radix-4 Booth multiplier with a start/done handshake and a selectable signed or unsigned mode. It retires one Booth digit per clock and delivers the 2·WIDTH-bit product on HI/LO. It is the multi-cycle successor to the single-cycle combinational multiplier in the ALU datapath. It trades latency for area and adds unsigned multiply, which the MUL/MULU control path needs.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be even and ≥ 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous and active-high.
- start  in  1  request a multiply; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- A  in  WIDTH  multiplicand; captured with start.
- B  in  WIDTH  multiplier; captured with start.
- busy  out  1  high while an operation is in progress (RUN or DONE).
- done  out  1  one-cycle pulse; the result is valid.
- HI  out  WIDTH  upper half of the product.
- LO  out  WIDTH  lower half of the product.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE when the last digit retires.
  - DONE → IDLE unconditionally.
- Operand capture in IDLE with start:
  - A is extended by 2 bits to WIDTH+2 bits: sign-extended if signed_mode, zero-extended otherwise.
  - B is extended the same way to WIDTH+2 bits, with an overlap bit b₋₁ = 0 appended.
  - The iteration count is K = WIDTH/2 + 1, so the top (extension) digit makes unsigned operands correct.
- Each RUN cycle:
  - Decode triplet {b2i+1, b2i, b2i−1} to a digit in {0, ±A, ±2A}: 000/111→0, 001/010→+A, 011→+2A, 100→−2A, 101/110→−A.
  - Add the digit, shifted left by 2i, into a 2·WIDTH+4-bit signed accumulator.
  - Shift the multiplier register right by 2 and increment the digit counter.
- On the RUN → DONE transition:
  - Load HI/LO from accumulator bits [2·WIDTH−1:0].
  - The result is exact modulo 2^(2·WIDTH), in signed or unsigned interpretation per the captured mode.
- HI/LO hold their value until the next operation's DONE. They do not change during RUN.
- start outside IDLE is ignored; it is neither queued nor does it corrupt the operation.
- Changes on A, B and signed_mode after capture have no effect.
- clr in any state:
  - next state IDLE;
  - busy = 0, done = 0, HI = 0, LO = 0;
  - accumulator and counter cleared.
  - clr wins over a simultaneous start.

## Timing
- Reset values: busy 0, done 0, HI 0, LO 0, state IDLE.
- Let start be sampled at edge 0.
  - Edges 1…K perform the iterations.
  - HI/LO update and done rises at edge K.
  - done falls and the FSM returns to IDLE at edge K+1.
- busy is high from edge 0 through edge K+1; it is low after edge K+1.
- With WIDTH = 32, latency is 17 cycles (start edge to done visible).
- A new start is accepted no earlier than the cycle after done, giving a throughput of one multiply per K+2 cycles.
- Back-to-back: start held high continuously launches a new operation every K+2 cycles.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - After each RUN iteration, if the remaining unscanned multiplier bits (including the overlap bit) are all 0 or all 1, every remaining digit is zero and the FSM goes directly to DONE.
  - At least 1 iteration is always performed.
  - Latency becomes data-dependent (1…K); the result is bit-identical.
- MUL_EARLY_EXIT_EN undefined:
  - Fixed latency of K iterations for every operand.
  - No all-zero/all-one detection logic is present.

## Test plan
- WIDTH=32, signed, A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0x00000000, LO=0x00000001; done exactly 17 cycles after start; busy high for 19 edges.
- WIDTH=32, unsigned, A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- WIDTH=32, signed, A=B=0x80000000 → HI=0x40000000, LO=0x00000000. Also signed A=7, B=0xFFFFFFFD → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Start A=7, B=3. Pulse start with A=9 at cycle 5, then pulse clr at cycle 8 → the second start is ignored; after clr, HI=LO=0, busy=0, and no done pulse. A fresh start 7×3 → LO=0x15.
- With MUL_EARLY_EXIT_EN, signed A=5, B=3 → LO=0x0F, done 2 cycles after start. B=0 → LO=0, done 1 cycle after start. Without the macro, both take 17 cycles.
- WIDTH=8, 1000 random signed and unsigned pairs checked against the reference product → all match; done latency is 5 without the macro.
